// File: rtl/ram256x32_bist_ctrl.sv
// ram256x32_bist_ctrl - self-test master for a 256x32 single-port RAM.
//
// When start is accepted, the block writes an LFSR pattern to every address in
// ascending order, reads every address back and compares each read word with
// the pattern. It reports pass/fail, a saturating mismatch count, and the
// address, expected word and read word of the first mismatch.
//
// Optional feature (compile-time macro RAM_BIST_INV_EN): after the first
// write/read pass, a second pass runs with the inverted pattern, so stuck bits
// are caught in both polarities. Without the macro only the single pass exists.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start_i            begin a test (sampled in IDLE/DONE only)
//   busy_o, done_o     test running / test finished (held until next start)
//   pass_o             1 = no mismatch (valid while done_o)
//   err_cnt_o          number of mismatching reads, saturating
//   fail_adrs_o/exp_o/got_o  first mismatch record
//   ram_cs_o (active-low), ram_rw_o (1 = write), ram_adrs_o, ram_data_in_o,
//   ram_data_out_i     RAM port; read data arrives RD_LAT clocks after the read
module ram256x32_bist_ctrl #(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 32,
  parameter int                RD_LAT = 1,
  parameter logic [DATA_W-1:0] SEED   = 32'hACE1_2468,
  parameter logic [DATA_W-1:0] POLY   = 32'h8020_0003
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W+1:0] err_cnt_o,
  output logic [ADDR_W-1:0] fail_adrs_o,
  output logic [DATA_W-1:0] fail_exp_o,
  output logic [DATA_W-1:0] fail_got_o,
  output logic              ram_cs_o,
  output logic              ram_rw_o,
  output logic [ADDR_W-1:0] ram_adrs_o,
  output logic [DATA_W-1:0] ram_data_in_o,
  input  logic [DATA_W-1:0] ram_data_out_i
);

  localparam int                ERR_W   = ADDR_W + 2;
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [DATA_W-1:0] SEED_NZ = (SEED == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [ADDR_W-1:0] ADR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
`ifdef RAM_BIST_INV_EN
    , S_WRITE_INV = 3'd5
    , S_READ_INV  = 3'd6
`endif
  } state_e;

  // Galois step, shifting right; POLY is xor-ed in when bit 0 falls out.
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
    return (v >> 1) ^ (v[0] ? POLY : {DATA_W{1'b0}});
  endfunction

  state_e              state_q, state_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   fail_adrs_q, fail_adrs_d;
  logic [DATA_W-1:0]   fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;
  logic                ram_cs_q, ram_cs_d, ram_rw_q, ram_rw_d;
  logic [ADDR_W-1:0]   ram_adrs_q, ram_adrs_d;
  logic [DATA_W-1:0]   ram_data_in_q, ram_data_in_d;
  logic [DATA_W-1:0]   lfsr_q, lfsr_d;
  logic [2:0]          drain_q, drain_d;
  logic [2:0]          drain_last_s;
  logic                push_vld_s;
  logic [DATA_W-1:0]   push_exp_s;
`ifdef RAM_BIST_INV_EN
  logic                inv_q, inv_d;
`endif

  // Expected word and address of each outstanding read, aligned to RAM latency.
  logic                pipe_vld_q [RD_LAT];
  logic [DATA_W-1:0]   pipe_exp_q [RD_LAT];
  logic [ADDR_W-1:0]   pipe_adr_q [RD_LAT];

`ifdef RAM_BIST_INV_EN
  // The drain between the two passes has one extra turnaround cycle.
  assign drain_last_s = inv_q ? 3'(RD_LAT - 1) : 3'(RD_LAT);
`else
  assign drain_last_s = 3'(RD_LAT - 1);
`endif

  // Next-state, RAM access sequencing and compare/record logic.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    err_cnt_d     = err_cnt_q;
    fail_adrs_d   = fail_adrs_q;
    fail_exp_d    = fail_exp_q;
    fail_got_d    = fail_got_q;
    ram_cs_d      = ram_cs_q;
    ram_rw_d      = ram_rw_q;
    ram_adrs_d    = ram_adrs_q;
    ram_data_in_d = ram_data_in_q;
    lfsr_d        = lfsr_q;
    drain_d       = drain_q;
    push_vld_s    = 1'b0;
    push_exp_s    = lfsr_q;
`ifdef RAM_BIST_INV_EN
    inv_d         = inv_q;
`endif

    // Retire the oldest outstanding read; only the first mismatch is recorded.
    if (pipe_vld_q[RD_LAT-1] && (ram_data_out_i != pipe_exp_q[RD_LAT-1])) begin
      if (err_cnt_q == '0) begin
        fail_adrs_d = pipe_adr_q[RD_LAT-1];
        fail_exp_d  = pipe_exp_q[RD_LAT-1];
        fail_got_d  = ram_data_out_i;
      end
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_ONE;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        ram_cs_d = 1'b1;
        if (start_i) begin
          state_d       = S_WRITE;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          err_cnt_d     = '0;
          fail_adrs_d   = '0;
          fail_exp_d    = '0;
          fail_got_d    = '0;
          ram_cs_d      = 1'b0;
          ram_rw_d      = 1'b1;
          ram_adrs_d    = '0;
          ram_data_in_d = SEED_NZ;
          lfsr_d        = SEED_NZ;
`ifdef RAM_BIST_INV_EN
          inv_d         = 1'b0;
`endif
        end
      end
`ifdef RAM_BIST_INV_EN
      S_WRITE, S_WRITE_INV: begin
`else
      S_WRITE: begin
`endif
        if (ram_adrs_q == ADR_MAX) begin
`ifdef RAM_BIST_INV_EN
          state_d = inv_q ? S_READ_INV : S_READ;
`else
          state_d = S_READ;
`endif
          ram_rw_d   = 1'b0;
          ram_adrs_d = '0;
          lfsr_d     = SEED_NZ;
        end else begin
          ram_adrs_d = ram_adrs_q + ADR_ONE;
          lfsr_d     = lfsr_next(lfsr_q);
`ifdef RAM_BIST_INV_EN
          ram_data_in_d = inv_q ? ~lfsr_next(lfsr_q) : lfsr_next(lfsr_q);
`else
          ram_data_in_d = lfsr_next(lfsr_q);
`endif
        end
      end
`ifdef RAM_BIST_INV_EN
      S_READ, S_READ_INV: begin
        push_exp_s = inv_q ? ~lfsr_q : lfsr_q;
`else
      S_READ: begin
`endif
        push_vld_s = 1'b1;
        if (ram_adrs_q == ADR_MAX) begin
          state_d  = S_DRAIN;
          ram_cs_d = 1'b1;
          drain_d  = 3'd0;
        end else begin
          ram_adrs_d = ram_adrs_q + ADR_ONE;
          lfsr_d     = lfsr_next(lfsr_q);
        end
      end
      S_DRAIN: begin
        ram_cs_d = 1'b1;
        if (drain_q == drain_last_s) begin
`ifdef RAM_BIST_INV_EN
          if (!inv_q) begin
            state_d       = S_WRITE_INV;
            inv_d         = 1'b1;
            ram_cs_d      = 1'b0;
            ram_rw_d      = 1'b1;
            ram_adrs_d    = '0;
            lfsr_d        = SEED_NZ;
            ram_data_in_d = ~SEED_NZ;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // err_cnt_d already includes the compare retiring on this edge.
          pass_d  = (err_cnt_d == '0);
`endif
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        ram_cs_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_cnt_q     <= '0;
      fail_adrs_q   <= '0;
      fail_exp_q    <= '0;
      fail_got_q    <= '0;
      ram_cs_q      <= 1'b1;
      ram_rw_q      <= 1'b0;
      ram_adrs_q    <= '0;
      ram_data_in_q <= '0;
      lfsr_q        <= SEED_NZ;
      drain_q       <= 3'd0;
`ifdef RAM_BIST_INV_EN
      inv_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_cnt_q     <= err_cnt_d;
      fail_adrs_q   <= fail_adrs_d;
      fail_exp_q    <= fail_exp_d;
      fail_got_q    <= fail_got_d;
      ram_cs_q      <= ram_cs_d;
      ram_rw_q      <= ram_rw_d;
      ram_adrs_q    <= ram_adrs_d;
      ram_data_in_q <= ram_data_in_d;
      lfsr_q        <= lfsr_d;
      drain_q       <= drain_d;
`ifdef RAM_BIST_INV_EN
      inv_q         <= inv_d;
`endif
    end
  end

  // Read-compare pipeline: entry 0 captures the read issued this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_exp_q[i] <= '0;
        pipe_adr_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= push_vld_s;
      pipe_exp_q[0] <= push_exp_s;
      pipe_adr_q[0] <= ram_adrs_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_exp_q[i] <= pipe_exp_q[i-1];
        pipe_adr_q[i] <= pipe_adr_q[i-1];
      end
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign err_cnt_o     = err_cnt_q;
  assign fail_adrs_o   = fail_adrs_q;
  assign fail_exp_o    = fail_exp_q;
  assign fail_got_o    = fail_got_q;
  assign ram_cs_o      = ram_cs_q;
  assign ram_rw_o      = ram_rw_q;
  assign ram_adrs_o    = ram_adrs_q;
  assign ram_data_in_o = ram_data_in_q;

endmodule

// File: tb/tb_ram256x32_bist_ctrl.sv
// Bench for ram256x32_bist_ctrl: a behavioural RAM with injectable stuck-at
// and bit-flip faults, plus a reference model that derives the expected
// pass/err_cnt/first-failure from the pattern and the fault maps.
// Latency is counted in clock edges from the edge that accepts start to the
// edge that sets done.
module tb_ram256x32_bist_ctrl;

  localparam int          ADDR_W = 8;
  localparam int          DATA_W = 32;
  localparam int          RD_LAT = 1;
  localparam int          NW     = 256;
  localparam logic [31:0] SEED   = 32'hACE1_2468;
  localparam logic [31:0] POLY   = 32'h8020_0003;
`ifdef RAM_BIST_INV_EN
  localparam int PASSES = 2;
  localparam int LAT    = 4 * NW + 2 * RD_LAT + 1;
`else
  localparam int PASSES = 1;
  localparam int LAT    = 2 * NW + RD_LAT;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, pass;
  logic [9:0]  err_cnt;
  logic [7:0]  fail_adrs;
  logic [31:0] fail_exp, fail_got;
  logic        ram_cs, ram_rw;
  logic [7:0]  ram_adrs;
  logic [31:0] ram_data_in, ram_data_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] pat  [NW];
  logic [31:0] mem  [NW];
  logic [31:0] s0   [NW];
  logic [31:0] s1   [NW];
  logic [31:0] flip [NW];
  logic [31:0] rd_pipe [RD_LAT];

  ram256x32_bist_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .SEED(SEED), .POLY(POLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
    .fail_adrs_o(fail_adrs), .fail_exp_o(fail_exp), .fail_got_o(fail_got),
    .ram_cs_o(ram_cs), .ram_rw_o(ram_rw), .ram_adrs_o(ram_adrs),
    .ram_data_in_o(ram_data_in), .ram_data_out_i(ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: faults act on the read path; idle cycles return junk.
  always @(posedge clk) begin
    if (!ram_cs && ram_rw) mem[ram_adrs] <= ram_data_in;
    rd_pipe[0] <= (!ram_cs && !ram_rw)
                  ? (((mem[ram_adrs] & ~s0[ram_adrs]) | s1[ram_adrs]) ^ flip[ram_adrs])
                  : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_data_out = rd_pipe[RD_LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < NW; a++) begin
      s0[a] = 32'h0; s1[a] = 32'h0; flip[a] = 32'h0;
    end
  endtask

  // Reference: every address written with the pattern (inverted on pass 2),
  // then read through the fault maps; mismatches counted in address order.
  task automatic model(output int cnt, output logic [7:0] fa, output logic [31:0] fe,
                       output logic [31:0] fg);
    logic [31:0] w, g;
    cnt = 0; fa = 8'h0; fe = 32'h0; fg = 32'h0;
    for (int p = 0; p < PASSES; p++) begin
      for (int a = 0; a < NW; a++) begin
        w = (p == 1) ? ~pat[a] : pat[a];
        g = ((w & ~s0[a]) | s1[a]) ^ flip[a];
        if (g != w) begin
          if (cnt == 0) begin fa = 8'(a); fe = w; fg = g; end
          if (cnt < 1023) cnt++;
        end
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_done"}, 64'(done), 64'(0));
    check_eq({tag, "_pass"}, 64'(pass), 64'(0));
    check_eq({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
    check_eq({tag, "_fail_adrs"}, 64'(fail_adrs), 64'(0));
    check_eq({tag, "_fail_exp"}, 64'(fail_exp), 64'(0));
    check_eq({tag, "_fail_got"}, 64'(fail_got), 64'(0));
    check_eq({tag, "_ram_cs"}, 64'(ram_cs), 64'(1));
    check_eq({tag, "_ram_rw"}, 64'(ram_rw), 64'(0));
    check_eq({tag, "_ram_adrs"}, 64'(ram_adrs), 64'(0));
    check_eq({tag, "_ram_data_in"}, 64'(ram_data_in), 64'(0));
  endtask

  task automatic kick(input bit hold);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Follows one test after the accepting edge, checking the issued accesses.
  task automatic wait_done(input string tag, input int pulse_at, input int abort_at,
                           input bit hold);
    int n = 0, wr = 0, rd = 0, bad = 0, lat = -1;
    bit aborted = 1'b0;
    while (n <= LAT + 50) begin
      if (!ram_cs) begin
        if (ram_rw) begin
          if (ram_adrs != 8'(wr)) bad++;
          if (ram_data_in != ((wr >= NW) ? ~pat[ram_adrs] : pat[ram_adrs])) bad++;
          wr++;
        end else begin
          if (ram_adrs != 8'(rd)) bad++;
          rd++;
        end
      end
      if (done) begin lat = n; break; end
      if (n == abort_at) begin
        check_eq({tag, "_abort_adrs"}, 64'(ram_adrs), 64'(8'h80));
        rst_n = 1'b0; #1;
        aborted = 1'b1;
        break;
      end
      if (n == pulse_at) start = 1'b1;
      else if (!hold) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (!aborted) begin
      check_eq({tag, "_latency"}, 64'(lat), 64'(LAT));
      check_eq({tag, "_writes"}, 64'(wr), 64'(PASSES * NW));
      check_eq({tag, "_reads"}, 64'(rd), 64'(PASSES * NW));
      check_eq({tag, "_access_seq"}, 64'(bad), 64'(0));
    end
  endtask

  task automatic verify(input string tag);
    int cnt; logic [7:0] fa; logic [31:0] fe, fg;
    model(cnt, fa, fe, fg);
    check_eq({tag, "_done"}, 64'(done), 64'(1));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_ram_cs"}, 64'(ram_cs), 64'(1));
    check_eq({tag, "_pass"}, 64'(pass), 64'(cnt == 0));
    check_eq({tag, "_err_cnt"}, 64'(err_cnt), 64'(cnt));
    check_eq({tag, "_fail_adrs"}, 64'(fail_adrs), 64'(fa));
    check_eq({tag, "_fail_exp"}, 64'(fail_exp), 64'(fe));
    check_eq({tag, "_fail_got"}, 64'(fail_got), 64'(fg));
  endtask

  task automatic run_test(input string tag);
    kick(1'b0);
    wait_done(tag, -1, -1, 1'b0);
    verify(tag);
  endtask

  initial begin
    logic [31:0] v, m;
    int b, a, k;
    v = SEED;
    for (int i = 0; i < NW; i++) begin
      pat[i] = v;
      v = (v >> 1) ^ (v[0] ? POLY : 32'h0);
    end
    clear_faults();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) check_eq("idle_busy", 64'(busy), 64'(0));

    // fault-free RAM
    run_test("fault_free");

    // stuck-0 at address 0x10 on a bit the pattern holds at 1
    clear_faults();
    b = $urandom_range(0, 31);
    for (int j = 0; j < 32; j++) begin
      if (pat[16][(b + j) % 32]) begin b = (b + j) % 32; break; end
    end
    s0[16] = 32'h1 << b;
    run_test("stuck0_0x10");
    check_eq("stuck0_got_vs_exp", 64'(fail_got), 64'(fail_exp & ~(32'h1 << b)));

    // two corrupted words: first failure must stay at 0x05
    clear_faults();
    m = $urandom; if (m == 32'h0) m = 32'h1; flip[5] = m;
    m = $urandom; if (m == 32'h0) m = 32'h1; flip[240] = m;
    run_test("two_faults");

    // random fault sets, stuck-1 and flips mixed
    for (int t = 0; t < 3; t++) begin
      clear_faults();
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        a = $urandom_range(0, NW - 1);
        m = $urandom; if (m == 32'h0) m = 32'h1;
        if ($urandom_range(0, 1) == 1) flip[a] = m; else s1[a] = s1[a] | m;
      end
      run_test($sformatf("random%0d", t));
    end

    // start pulsed while writing address 0x40 must be ignored
    clear_faults();
    kick(1'b0);
    wait_done("start_busy", 64, -1, 1'b0);
    verify("start_busy");

    // reset during the read of address 0x80 aborts, then a restart passes
    kick(1'b0);
    wait_done("abort", -1, NW + 128, 1'b0);
    check_reset("abort");
    @(negedge clk) rst_n = 1'b1;
    run_test("after_abort");

    // start held high across DONE entry: accepted one edge later
    flip[77] = 32'h0000_0100;
    kick(1'b1);
    wait_done("hold", -1, -1, 1'b1);
    verify("hold");
    @(posedge clk); #1;
    check_eq("hold_restart_busy", 64'(busy), 64'(1));
    check_eq("hold_restart_done", 64'(done), 64'(0));
    start = 1'b0;
    wait_done("hold2", -1, -1, 1'b0);
    verify("hold2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
